// File: rtl/ascon_host_pkg.sv
// Shared types and defaults for the host-side bridge to the bit-serial Ascon wrapper.
package ascon_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        SHIFT,
        GAP,
        START,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    localparam int KEY_BITS   = 128;
    localparam int NONCE_BITS = 128;
    localparam int AD_BITS    = 40;
    localparam int DATA_BITS  = 104;
    localparam int TAG_BITS   = 128;

    localparam int CRST_CYCLES = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascon_serial_host_if.sv
// Parallel job interface between the register/bus front end (master) and the serial host (slave).
interface ascon_serial_host_if
    import ascon_host_pkg::*;
#(
    parameter int K = KEY_BITS,
    parameter int N = NONCE_BITS,
    parameter int L = AD_BITS,
    parameter int Y = DATA_BITS,
    parameter int T = TAG_BITS
) ();

    logic         start;
    logic         decrypt;
    logic [K-1:0] key_in;
    logic [N-1:0] nonce_in;
    logic [L-1:0] ad_in;
    logic [Y-1:0] data_in;
    logic         busy;
    logic         done;
    logic         error;
    logic [Y-1:0] result_data;
    logic [T-1:0] result_tag;

    modport master (
        output start, decrypt, key_in, nonce_in, ad_in, data_in,
        input  busy, done, error, result_data, result_tag
    );

    modport slave (
        input  start, decrypt, key_in, nonce_in, ad_in, data_in,
        output busy, done, error, result_data, result_tag
    );

endinterface

// File: rtl/ascon_piso.sv
// MSB-first parallel-load shift register; zeros shift in behind the field so
// short fields read as 0 once exhausted.
module ascon_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic         out_en,
    input  logic [W-1:0] din,
    output logic         so
);

    logic [W-1:0] sr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= din;
        end else if (shift) begin
            sr_reg <= sr_reg << 1;
        end
    end

    assign so = out_en & sr_reg[W-1];

endmodule

// File: rtl/ascon_serial_host.sv
// Host bridge: resets the serial Ascon wrapper, streams key/nonce/AD/data MSB-first,
// pulses start, then deserialises the LSB-first data and tag streams.
module ascon_serial_host
    import ascon_host_pkg::*;
#(
    parameter int K       = KEY_BITS,
    parameter int N       = NONCE_BITS,
    parameter int L       = AD_BITS,
    parameter int Y       = DATA_BITS,
    parameter int T       = TAG_BITS,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    ascon_serial_host_if.slave  bus,
    output logic                core_rst_so,
    output logic                key_so,
    output logic                nonce_so,
    output logic                ad_so,
    output logic                data_so,
    output logic                start_so,
    output logic                decrypt_so,
    input  logic                data_si,
    input  logic                tag_si,
    input  logic                core_ready_si
);

    localparam int M  = max2(max2(K, N), max2(L, Y));
    localparam int C  = max2(Y, T);
    localparam int CW = $clog2(max2(max2(M, C), TIMEOUT) + 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           error_reg, error_next;
    logic           decrypt_reg;
    logic           core_rst_reg;
    logic [Y-1:0]   result_data_reg;
    logic [T-1:0]   result_tag_reg;
    logic [Y-1:0]   data_hit;
    logic [T-1:0]   tag_hit;
    logic           accept;
    logic           shift_en;
    logic           cap_en;
    logic           busy;
    logic           done;
    logic           start_pulse;

    assign accept = (state_reg == IDLE) && bus.start;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        error_next  = error_reg;
        shift_en    = 1'b0;
        cap_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        start_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = CRST;
                    cnt_next   = '0;
                    error_next = 1'b0;
                end
            end
            CRST: begin
                busy = 1'b1;
                if (cnt_reg == CW'(CRST_CYCLES - 1)) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt_reg == CW'(M - 1)) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                busy       = 1'b1;
                state_next = START;
            end
            START: begin
                busy        = 1'b1;
                start_pulse = 1'b1;
                state_next  = WAIT;
                cnt_next    = '0;
            end
            WAIT: begin
                busy = 1'b1;
                // Ready wins over the timeout on the final WAIT cycle.
                if (core_ready_si) begin
                    state_next = CAPTURE;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    error_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (!core_ready_si) begin
                    state_next = DONE;
                    error_next = 1'b1;
                end else begin
                    cap_en = 1'b1;
                    if (cnt_reg == CW'(C - 1)) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            error_reg    <= 1'b0;
            decrypt_reg  <= 1'b0;
            core_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            error_reg    <= error_next;
            core_rst_reg <= (state_next == CRST);
            if (accept) begin
                decrypt_reg <= bus.decrypt;
            end
        end
    end

    // One-hot bit select for the current capture index m.
    genvar gi;
    generate
        for (gi = 0; gi < Y; gi++) begin : g_data_hit
            assign data_hit[gi] = cap_en && (cnt_reg == CW'(gi));
        end
        for (gi = 0; gi < T; gi++) begin : g_tag_hit
            assign tag_hit[gi] = cap_en && (cnt_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_data_reg <= '0;
            result_tag_reg  <= '0;
        end else if (accept) begin
            result_data_reg <= '0;
            result_tag_reg  <= '0;
        end else begin
            result_data_reg <= (result_data_reg & ~data_hit) | ({Y{data_si}} & data_hit);
            result_tag_reg  <= (result_tag_reg & ~tag_hit) | ({T{tag_si}} & tag_hit);
        end
    end

    ascon_piso #(.W(K)) u_key_piso (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_en),
        .out_en(state_reg == SHIFT), .din(bus.key_in), .so(key_so)
    );

    ascon_piso #(.W(N)) u_nonce_piso (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_en),
        .out_en(state_reg == SHIFT), .din(bus.nonce_in), .so(nonce_so)
    );

    ascon_piso #(.W(L)) u_ad_piso (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_en),
        .out_en(state_reg == SHIFT), .din(bus.ad_in), .so(ad_so)
    );

    ascon_piso #(.W(Y)) u_data_piso (
        .clk(clk), .rst(rst), .load(accept), .shift(shift_en),
        .out_en(state_reg == SHIFT), .din(bus.data_in), .so(data_so)
    );

    assign core_rst_so     = core_rst_reg;
    assign start_so        = start_pulse;
    assign decrypt_so      = decrypt_reg & busy;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.error       = error_reg;
    assign bus.result_data = result_data_reg;
    assign bus.result_tag  = result_tag_reg;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host against a behavioural serial-core stand-in
// whose transfer function is a simple invertible keyed mix.
module tb_ascon_serial_host;

    localparam int K = 128, N = 128, L = 40, Y = 104, T = 128;
    localparam int TIMEOUT = 4096;
    localparam int M = 128, C = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ascon_serial_host_if #(.K(K), .N(N), .L(L), .Y(Y), .T(T)) bus ();

    logic core_rst_so, key_so, nonce_so, ad_so, data_so, start_so, decrypt_so;
    logic data_si, tag_si, core_ready_si;

    ascon_serial_host #(.K(K), .N(N), .L(L), .Y(Y), .T(T), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .core_rst_so(core_rst_so), .key_so(key_so), .nonce_so(nonce_so),
        .ad_so(ad_so), .data_so(data_so), .start_so(start_so),
        .decrypt_so(decrypt_so), .data_si(data_si), .tag_si(tag_si),
        .core_ready_si(core_ready_si)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Core stand-in: data out = data in ^ keystream, tag over the plaintext.
    function automatic logic [Y+T-1:0] mock_fn(input logic [127:0] k, input logic [127:0] n,
                                               input logic [39:0] a, input logic [103:0] d,
                                               input logic dec);
        logic [103:0] ks, o, pt;
        logic [127:0] tg;
        ks = k[127:24] ^ n[103:0];
        o  = d ^ ks;
        pt = dec ? o : d;
        tg = k ^ {n[63:0], n[127:64]} ^ {pt, a[23:0]} ^ {88'h0, a};
        return {o, tg};
    endfunction

    logic never_ready = 1'b0;
    logic drop_en = 1'b0;
    int   drop_bit = 50;

    logic [M-1:0] k_sh, n_sh, a_sh, d_sh;
    int   in_cnt = 0;
    logic armed = 1'b0, ready_q = 1'b0, first = 1'b0;
    int   lat = 0, idx = 0;
    logic [Y-1:0] out_d = '0;
    logic [T-1:0] out_t = '0;

    always @(posedge clk) begin
        if (core_rst_so) begin
            in_cnt  <= 0;
            armed   <= 1'b0;
            ready_q <= 1'b0;
            first   <= 1'b0;
            idx     <= 0;
            lat     <= 0;
        end else begin
            if (in_cnt < M) begin
                k_sh   <= {k_sh[M-2:0], key_so};
                n_sh   <= {n_sh[M-2:0], nonce_so};
                a_sh   <= {a_sh[M-2:0], ad_so};
                d_sh   <= {d_sh[M-2:0], data_so};
                in_cnt <= in_cnt + 1;
            end
            if (start_so) begin
                {out_d, out_t} <= mock_fn(k_sh, n_sh, a_sh[M-1 -: L], d_sh[M-1 -: Y], decrypt_so);
                armed <= 1'b1;
                lat   <= 10;
            end else if (armed) begin
                if (lat == 0) begin
                    ready_q <= !never_ready;
                    armed   <= 1'b0;
                    idx     <= 0;
                    first   <= 1'b1;
                end else begin
                    lat <= lat - 1;
                end
            end else if (ready_q) begin
                if (first) first <= 1'b0;
                else if (idx == C - 1) ready_q <= 1'b0;
                else idx <= idx + 1;
            end
        end
    end

    assign core_ready_si = ready_q && !(drop_en && idx == drop_bit);
    assign data_si = (ready_q && idx < Y) ? out_d[idx] : 1'b0;
    assign tag_si  = (ready_q && idx < T) ? out_t[idx] : 1'b0;

    // Serial-line monitor; n counts cycles since core reset release.
    int mon_cyc = 0, key_mis = 0, ad_nz = 0, start_cnt = 0, start_at = -1;
    always @(negedge clk) begin
        if (core_rst_so) begin
            mon_cyc <= 0;
        end else if (bus.busy) begin
            mon_cyc <= mon_cyc + 1;
            if (mon_cyc < K && key_so !== bus.key_in[K-1-mon_cyc]) key_mis <= key_mis + 1;
            if (mon_cyc >= L && mon_cyc <= M && ad_so !== 1'b0) ad_nz <= ad_nz + 1;
            if (start_so) begin
                start_cnt <= start_cnt + 1;
                start_at  <= mon_cyc;
            end
        end
    end

    task automatic run_job(input logic dec, input logic [K-1:0] k, input logic [N-1:0] n,
                           input logic [L-1:0] a, input logic [Y-1:0] d, input int extra_start,
                           output int done_cnt, output int start_rel, output int done_rel);
        @(negedge clk);
        bus.key_in = k; bus.nonce_in = n; bus.ad_in = a; bus.data_in = d;
        bus.decrypt = dec; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0; start_rel = -1; done_rel = -1;
        for (int c = 1; c <= TIMEOUT + 400; c++) begin
            bus.start   = (c == extra_start);
            bus.decrypt = (c == extra_start) ? ~dec : dec;
            @(negedge clk);
            if (start_so) start_rel = c;
            if (bus.done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = c;
            end
            if (done_rel >= 0 && c > done_rel + 20) break;
        end
        bus.start = 1'b0;
        bus.decrypt = dec;
    endtask

    localparam logic [127:0] KAT_KEY   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT_NONCE = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [39:0]  KAT_AD    = 40'h0001020304;
    localparam logic [103:0] KAT_DATA  = 104'h000102030405060708090A0B0C;

    initial begin
        int dn, sr, dr, km0, an0, sc0, seen;
        logic [Y+T-1:0] exp;
        logic [Y-1:0] ct;
        logic [T-1:0] enc_tag;
        logic [103:0] dmask;
        logic [127:0] tmask;

        bus.start = 1'b0; bus.decrypt = 1'b0;
        bus.key_in = '0; bus.nonce_in = '0; bus.ad_in = '0; bus.data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_result_data", bus.result_data, 0);
        check("rst_result_tag", bus.result_tag, 0);
        check("rst_core_rst_so", core_rst_so, 1);
        check("rst_serial_lines", {key_so, nonce_so, ad_so, data_so, start_so, decrypt_so}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Known-answer encrypt through the stand-in core
        km0 = key_mis; an0 = ad_nz; sc0 = start_cnt;
        run_job(1'b0, KAT_KEY, KAT_NONCE, KAT_AD, KAT_DATA, -1, dn, sr, dr);
        exp = mock_fn(KAT_KEY, KAT_NONCE, KAT_AD, KAT_DATA, 1'b0);
        check("kat_done_count", dn, 1);
        check("kat_error", bus.error, 0);
        check("kat_data", bus.result_data, exp[Y+T-1:T]);
        check("kat_data_const", bus.result_data, 104'h030405060708090A0B0C0D0E0F);
        check("kat_tag", bus.result_tag, exp[T-1:0]);
        check("kat_key_so_mismatches", key_mis - km0, 0);
        check("kat_ad_so_nonzero_tail", ad_nz - an0, 0);
        check("kat_start_so_count", start_cnt - sc0, 1);
        check("kat_start_so_cycle", start_at, M + 1);
        ct = bus.result_data;
        enc_tag = bus.result_tag;

        // Round trip: decrypt the ciphertext
        run_job(1'b1, KAT_KEY, KAT_NONCE, KAT_AD, ct, -1, dn, sr, dr);
        check("rt_done_count", dn, 1);
        check("rt_data", bus.result_data, KAT_DATA);
        check("rt_tag", bus.result_tag, enc_tag);

        // Second vector with a stray start (opposite mode) while busy
        run_job(1'b0, 128'hFEDCBA9876543210_0F1E2D3C4B5A6978, 128'h0123456789ABCDEF_F0E1D2C3B4A59687,
                40'hA55AC33C99, 104'hDEADBEEF_CAFEF00D_12345678_9A, 60, dn, sr, dr);
        exp = mock_fn(128'hFEDCBA9876543210_0F1E2D3C4B5A6978, 128'h0123456789ABCDEF_F0E1D2C3B4A59687,
                      40'hA55AC33C99, 104'hDEADBEEF_CAFEF00D_12345678_9A, 1'b0);
        check("abuse_done_count", dn, 1);
        check("abuse_data", bus.result_data, exp[Y+T-1:T]);
        check("abuse_tag", bus.result_tag, exp[T-1:0]);

        // Ready drop at capture bit 50
        drop_en = 1'b1;
        run_job(1'b0, KAT_KEY, KAT_NONCE, KAT_AD, KAT_DATA, -1, dn, sr, dr);
        drop_en = 1'b0;
        exp = mock_fn(KAT_KEY, KAT_NONCE, KAT_AD, KAT_DATA, 1'b0);
        dmask = {54'h0, {50{1'b1}}};
        tmask = {78'h0, {50{1'b1}}};
        check("drop_done_count", dn, 1);
        check("drop_error", bus.error, 1);
        check("drop_data", bus.result_data, exp[Y+T-1:T] & dmask);
        check("drop_tag", bus.result_tag, exp[T-1:0] & tmask);

        // Start in the DONE cycle is ignored, accepted one cycle later
        @(negedge clk);
        bus.key_in = KAT_KEY; bus.nonce_in = KAT_NONCE; bus.ad_in = KAT_AD;
        bus.data_in = KAT_DATA; bus.decrypt = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
        end
        check("dc_done_seen", seen, 1);
        bus.start = 1'b1;
        @(negedge clk);
        check("dc_start_in_done_ignored", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("dc_start_next_accepted", bus.busy, 1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.done) break;
        end

        // Timeout: core never raises ready
        never_ready = 1'b1;
        run_job(1'b0, KAT_KEY, KAT_NONCE, KAT_AD, KAT_DATA, -1, dn, sr, dr);
        never_ready = 1'b0;
        check("to_done_count", dn, 1);
        check("to_error", bus.error, 1);
        check("to_result_data", bus.result_data, 0);
        check("to_result_tag", bus.result_tag, 0);
        check("to_latency", dr - sr, TIMEOUT + 1);

        // Asynchronous reset during SHIFT aborts without done
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("abort_core_rst_so", core_rst_so, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_error", bus.error, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", dn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
